// File: rtl/wb_unit_if.sv
// wb_unit_if: bundles the ALU result channel, the load-issue channel, the
// memory response channel and the register-file write port of wb_unit.
//   slave  : the writeback unit itself (consumes ALU/load/response traffic,
//            drives the write port, readiness, rd_pending and err)
//   master : whatever feeds the unit (pipeline stages or a testbench)
interface wb_unit_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;

   logic        ld_issue_valid;
   logic        ld_issue_ready;
   logic [4:0]  ld_issue_rd;
   logic [2:0]  ld_issue_funct3;
   logic [1:0]  ld_issue_offset;

   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   logic        we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] rd_pending;
   logic        err;

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_offset,
      output ld_issue_ready,
      input  mem_resp_valid, mem_resp_data,
      output we, wb_addr, wb_data, rd_pending, err
   );

   modport master (
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_offset,
      input  ld_issue_ready,
      output mem_resp_valid, mem_resp_data,
      input  we, wb_addr, wb_data, rd_pending, err
   );
endinterface

// File: rtl/wb_unit.sv
// wb_unit: register-file write-side driver. Merges in-order load responses
// and ALU results onto the single write port, formats load data, and tracks
// registers with outstanding loads.
// Ports:
//   clk    - clock, all state on posedge
//   reset  - synchronous active-high reset
//   bus    - wb_unit_if.slave: ALU channel (valid/ready), load-issue channel
//            (valid/ready + rd/funct3/offset), memory response (valid/data,
//            never stalled), registered write port (we/wb_addr/wb_data),
//            rd_pending bitmap and sticky err.
module wb_unit #(
   parameter int LD_DEPTH = 2
) (
   input logic       clk,
   input logic       reset,
   wb_unit_if.slave  bus
);
   localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;

   // Load queue: storage has no reset, occupancy is tracked per slot.
   logic [4:0]          q_rd_reg  [LD_DEPTH];
   logic [2:0]          q_f3_reg  [LD_DEPTH];
   logic [1:0]          q_off_reg [LD_DEPTH];
   logic [LD_DEPTH-1:0] q_valid_reg, q_valid_next;
   logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;

   logic        hold_valid_reg;
   logic [4:0]  hold_rd_reg;
   logic [31:0] hold_data_reg;

   logic        we_reg;
   logic [4:0]  wb_addr_reg;
   logic [31:0] wb_data_reg;
   logic        err_reg;

   logic        fifo_empty, fifo_full, push, pop, alu_take, bad_f3;
   logic [4:0]  head_rd;
   logic [2:0]  head_f3;
   logic [1:0]  head_off;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ld_fmt;

   assign fifo_empty = ~|q_valid_reg;
   assign fifo_full  = &q_valid_reg;
   // Readiness depends on start-of-cycle state only: a same-cycle pop never
   // opens a slot for an issue, and the ALU stalls whenever the hold is full.
   assign push     = bus.ld_issue_valid && !fifo_full;
   assign pop      = bus.mem_resp_valid && !fifo_empty;
   assign alu_take = bus.alu_valid && !hold_valid_reg;

   assign head_rd  = q_rd_reg[rd_ptr_reg];
   assign head_f3  = q_f3_reg[rd_ptr_reg];
   assign head_off = q_off_reg[rd_ptr_reg];

   always_comb begin
      q_valid_next = q_valid_reg;
      if (pop)
         q_valid_next[rd_ptr_reg] = 1'b0;
      if (push)
         q_valid_next[wr_ptr_reg] = 1'b1;
   end

   // Load formatting: byte lane = offset, half lane = offset[1].
   always_comb begin
      case (head_off)
         2'd0:    byte_sel = bus.mem_resp_data[7:0];
         2'd1:    byte_sel = bus.mem_resp_data[15:8];
         2'd2:    byte_sel = bus.mem_resp_data[23:16];
         default: byte_sel = bus.mem_resp_data[31:24];
      endcase
      half_sel = head_off[1] ? bus.mem_resp_data[31:16] : bus.mem_resp_data[15:0];
      bad_f3   = 1'b0;
      case (head_f3)
         3'b000:  ld_fmt = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ld_fmt = {24'd0, byte_sel};
         3'b001:  ld_fmt = {{16{half_sel[15]}}, half_sel};
         3'b101:  ld_fmt = {16'd0, half_sel};
         3'b010:  ld_fmt = bus.mem_resp_data;
         default: begin
            ld_fmt = bus.mem_resp_data;
            bad_f3 = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_rd_reg[wr_ptr_reg]  <= bus.ld_issue_rd;
         q_f3_reg[wr_ptr_reg]  <= bus.ld_issue_funct3;
         q_off_reg[wr_ptr_reg] <= bus.ld_issue_offset;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_valid_reg    <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         hold_valid_reg <= 1'b0;
         hold_rd_reg    <= '0;
         hold_data_reg  <= '0;
         we_reg         <= 1'b0;
         wb_addr_reg    <= '0;
         wb_data_reg    <= '0;
         err_reg        <= 1'b0;
      end else begin
         q_valid_reg <= q_valid_next;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;

         if ((bus.mem_resp_valid && fifo_empty) || (pop && bad_f3))
            err_reg <= 1'b1;

         // Priority: load response, then held ALU result, then new ALU input.
         // A winning write to x0 still consumes its source but raises no we.
         we_reg <= 1'b0;
         if (pop) begin
            we_reg      <= (head_rd != 5'd0);
            wb_addr_reg <= head_rd;
            wb_data_reg <= ld_fmt;
            if (alu_take) begin
               hold_valid_reg <= 1'b1;
               hold_rd_reg    <= bus.alu_rd;
               hold_data_reg  <= bus.alu_data;
            end
         end else if (hold_valid_reg) begin
            we_reg         <= (hold_rd_reg != 5'd0);
            wb_addr_reg    <= hold_rd_reg;
            wb_data_reg    <= hold_data_reg;
            hold_valid_reg <= 1'b0;
         end else if (alu_take) begin
            we_reg      <= (bus.alu_rd != 5'd0);
            wb_addr_reg <= bus.alu_rd;
            wb_data_reg <= bus.alu_data;
         end
      end
   end

   // rd_pending is derived from the queue contents, so a bit stays set while
   // any remaining entry targets that register and clears on the popping edge.
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_pend
         if (gi == 0) begin : g_x0
            assign bus.rd_pending[gi] = 1'b0;
         end else begin : g_xn
            logic hit;
            always_comb begin
               hit = 1'b0;
               for (int k = 0; k < LD_DEPTH; k++)
                  if (q_valid_reg[k] && (q_rd_reg[k] == 5'(gi)))
                     hit = 1'b1;
            end
            assign bus.rd_pending[gi] = hit;
         end
      end
   endgenerate

   assign bus.alu_ready      = !hold_valid_reg;
   assign bus.ld_issue_ready = !fifo_full;
   assign bus.we             = we_reg;
   assign bus.wb_addr        = wb_addr_reg;
   assign bus.wb_data        = wb_data_reg;
   assign bus.err            = err_reg;
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: scoreboard bench for wb_unit. Expected writes are queued when
// the stimulus that causes them is driven; a negedge monitor pops and
// compares every register-file write.
module tb_wb_unit;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   logic [36:0] exp_q [$];

   wb_unit_if bus ();

   wb_unit #(.LD_DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Register-file write monitor: every we pulse must match the scoreboard head.
   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         $display("write x%0d <= %h", bus.wb_addr, bus.wb_data);
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(bus.wb_addr), 32'hFFFF_FFFF);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("wb_addr", 32'(bus.wb_addr), 32'(e[36:32]));
            check("wb_data", bus.wb_data, e[31:0]);
         end
      end
   end

   task automatic alu_op(input logic [4:0] rd, input logic [31:0] d);
      $display("alu    rd=%0d data=%h", rd, d);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = rd;
      bus.alu_data  = d;
      if (rd != 5'd0)
         exp_q.push_back({rd, d});
      tick();
      bus.alu_valid = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
      $display("issue  rd=%0d funct3=%0d offset=%0d", rd, f3, off);
      bus.ld_issue_valid  = 1'b1;
      bus.ld_issue_rd     = rd;
      bus.ld_issue_funct3 = f3;
      bus.ld_issue_offset = off;
      tick();
      bus.ld_issue_valid = 1'b0;
   endtask

   task automatic resp(input logic [31:0] d, input logic [4:0] rd, input logic [31:0] val);
      $display("resp   data=%h expect x%0d=%h", d, rd, val);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = d;
      if (rd != 5'd0)
         exp_q.push_back({rd, val});
      tick();
      bus.mem_resp_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      bus.alu_valid = 1'b0;       bus.alu_rd = '0;          bus.alu_data = '0;
      bus.ld_issue_valid = 1'b0;  bus.ld_issue_rd = '0;
      bus.ld_issue_funct3 = '0;   bus.ld_issue_offset = '0;
      bus.mem_resp_valid = 1'b0;  bus.mem_resp_data = '0;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_we", 32'(bus.we), 32'd0);
      check("rst_addr", 32'(bus.wb_addr), 32'd0);
      check("rst_data", bus.wb_data, 32'd0);
      check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
      check("rst_ld_ready", 32'(bus.ld_issue_ready), 32'd1);
      check("rst_pending", bus.rd_pending, 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);

      // Direct ALU write, visible one cycle later.
      alu_op(5'd5, 32'h0000_1234);
      @(negedge clk);
      check("alu_we", 32'(bus.we), 32'd1);

      // Load formatting cases.
      issue(5'd7, 3'b000, 2'd2);
      @(negedge clk);
      check("lb_pending", bus.rd_pending, 32'h0000_0080);
      resp(32'h0080_0000, 5'd7, 32'hFFFF_FF80);
      @(negedge clk);
      check("lb_pending_clr", bus.rd_pending, 32'd0);
      issue(5'd7, 3'b100, 2'd2);
      resp(32'h0080_0000, 5'd7, 32'h0000_0080);
      issue(5'd7, 3'b001, 2'd3);
      resp(32'h8001_0000, 5'd7, 32'hFFFF_8001);
      issue(5'd8, 3'b101, 2'd2);
      resp(32'h8001_0000, 5'd8, 32'h0000_8001);
      issue(5'd2, 3'b010, 2'd1);
      resp(32'hDEAD_BEEF, 5'd2, 32'hDEAD_BEEF);

      // Collision: load response and ALU result in the same cycle.
      issue(5'd3, 3'b010, 2'd0);
      $display("collide load x3 / alu x4");
      bus.mem_resp_valid = 1'b1;  bus.mem_resp_data = 32'h1122_3344;
      exp_q.push_back({5'd3, 32'h1122_3344});
      bus.alu_valid = 1'b1;  bus.alu_rd = 5'd4;  bus.alu_data = 32'h0000_00AA;
      exp_q.push_back({5'd4, 32'h0000_00AA});
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.alu_valid = 1'b0;
      @(negedge clk);
      check("coll_alu_ready", 32'(bus.alu_ready), 32'd0);
      check("coll_we1", 32'(bus.we), 32'd1);
      tick();
      @(negedge clk);
      check("coll_we2", 32'(bus.we), 32'd1);
      check("coll_alu_ready2", 32'(bus.alu_ready), 32'd1);

      // Fill the queue with two loads to x9; a third issue must be refused.
      issue(5'd9, 3'b010, 2'd0);
      issue(5'd9, 3'b010, 2'd0);
      @(negedge clk);
      check("full_ready", 32'(bus.ld_issue_ready), 32'd0);
      issue(5'd10, 3'b010, 2'd0);
      @(negedge clk);
      check("full_pending", bus.rd_pending, 32'h0000_0200);
      resp(32'h0000_0001, 5'd9, 32'h0000_0001);
      @(negedge clk);
      check("x9_still_pending", bus.rd_pending, 32'h0000_0200);
      check("ready_after_pop", 32'(bus.ld_issue_ready), 32'd1);
      resp(32'h0000_0002, 5'd9, 32'h0000_0002);
      @(negedge clk);
      check("x9_cleared", bus.rd_pending, 32'd0);

      // Same-cycle push and pop on the same register: the bit stays set.
      issue(5'd11, 3'b010, 2'd0);
      $display("push+pop x11");
      bus.ld_issue_valid = 1'b1;  bus.ld_issue_rd = 5'd11;
      bus.ld_issue_funct3 = 3'b010;  bus.ld_issue_offset = 2'd0;
      bus.mem_resp_valid = 1'b1;  bus.mem_resp_data = 32'h0000_0055;
      exp_q.push_back({5'd11, 32'h0000_0055});
      tick();
      bus.ld_issue_valid = 1'b0;
      bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      check("setwins_pending", bus.rd_pending, 32'h0000_0800);
      resp(32'h0000_0066, 5'd11, 32'h0000_0066);
      @(negedge clk);
      check("x11_cleared", bus.rd_pending, 32'd0);
      check("err_clean", 32'(bus.err), 32'd0);

      // Stray response with an empty queue.
      $display("stray response");
      bus.mem_resp_valid = 1'b1;  bus.mem_resp_data = 32'h0000_0099;
      tick();
      bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      check("stray_we", 32'(bus.we), 32'd0);
      check("stray_err", 32'(bus.err), 32'd1);
      alu_op(5'd0, 32'h0000_0055);
      @(negedge clk);
      check("x0_we", 32'(bus.we), 32'd0);
      tick();
      tick();
      @(negedge clk);
      check("err_sticky", 32'(bus.err), 32'd1);

      // Reset with one load queued and the hold buffer full.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      issue(5'd12, 3'b010, 2'd0);
      issue(5'd13, 3'b010, 2'd0);
      $display("collide load x12 / alu x14 then reset");
      bus.mem_resp_valid = 1'b1;  bus.mem_resp_data = 32'h0000_0C0C;
      exp_q.push_back({5'd12, 32'h0000_0C0C});
      bus.alu_valid = 1'b1;  bus.alu_rd = 5'd14;  bus.alu_data = 32'h0000_0E0E;
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.alu_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("pre_rst_alu_ready", 32'(bus.alu_ready), 32'd0);
      check("pre_rst_pending", bus.rd_pending, 32'h0000_2000);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_we", 32'(bus.we), 32'd0);
      check("post_rst_pending", bus.rd_pending, 32'd0);
      check("post_rst_alu_ready", 32'(bus.alu_ready), 32'd1);
      check("post_rst_err", 32'(bus.err), 32'd0);
      tick();
      @(negedge clk);
      check("post_rst_we2", 32'(bus.we), 32'd0);
      $display("stray response after reset");
      bus.mem_resp_valid = 1'b1;  bus.mem_resp_data = 32'h0000_1111;
      tick();
      bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      check("post_rst_stray_err", 32'(bus.err), 32'd1);
      check("post_rst_stray_we", 32'(bus.we), 32'd0);

      // Reserved funct3 behaves as LW and raises err.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("err_cleared", 32'(bus.err), 32'd0);
      issue(5'd6, 3'b110, 2'd1);
      resp(32'h1234_5678, 5'd6, 32'h1234_5678);
      @(negedge clk);
      check("badf3_err", 32'(bus.err), 32'd1);

      tick();
      tick();
      @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
